// File: rtl/rx_push_arbiter_pkg.sv
// Shared constants and types for the RX push arbiter: port indices,
// idle grant code, FSM state encoding and the round-robin pointer step.
`ifndef SIZE
`define SIZE 32
`endif

package rx_push_arbiter_pkg;

  localparam int unsigned NPORTS = 5;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t PORT_N     = 3'd0;
  localparam port_idx_t PORT_S     = 3'd1;
  localparam port_idx_t PORT_E     = 3'd2;
  localparam port_idx_t PORT_W     = 3'd3;
  localparam port_idx_t PORT_L     = 3'd4;
  localparam port_idx_t GRANT_NONE = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWrite   = 2'd1,
    StWaitRel = 2'd2
  } state_e;

  // Pointer position just after port g, wrapping 4 -> 0.
  function automatic port_idx_t next_ptr(input port_idx_t g);
    return (g >= port_idx_t'(NPORTS - 1)) ? 3'd0 : g + 3'd1;
  endfunction

endpackage

// File: rtl/rx_push_arbiter_if.sv
// Bundle of the five RX push channels plus the shared FIFO write port.
// master: arbiter side. slave: transceivers/FIFO side.
`ifndef SIZE
`define SIZE 32
`endif

interface rx_push_arbiter_if #(
  parameter int unsigned DATA_W = `SIZE
);
  logic [4:0]          fifo_push_req;
  logic [4:0]          fifo_push_ack;
  logic [5*DATA_W-1:0] fifo_push_data;
  logic                fifo_write;
  logic                fifo_full;
  logic [DATA_W-1:0]   fifo_item_in;
  logic [2:0]          grant_port;

  modport master (
    input  fifo_push_req,
    input  fifo_push_data,
    input  fifo_full,
    output fifo_push_ack,
    output fifo_write,
    output fifo_item_in,
    output grant_port
  );

  modport slave (
    output fifo_push_req,
    output fifo_push_data,
    output fifo_full,
    input  fifo_push_ack,
    input  fifo_write,
    input  fifo_item_in,
    input  grant_port
  );
endinterface

// File: rtl/rx_push_arbiter_rr_pick5.sv
// rr_pick5: combinational rotate-priority picker over five requests.
// Returns the first set request at or after ptr, wrapping 4 -> 0.
module rr_pick5
  import rx_push_arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  port_idx_t  ptr,
  output logic       valid,
  output port_idx_t  idx
);

  port_idx_t cand;

  // Scan from farthest to nearest so the closest requester to ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = port_idx_t'((32'(ptr) + 32'(k)) % NPORTS);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rx_push_arbiter.sv
// rx_push_arbiter: shares one FIFO write port among the N/S/E/W/L RX push
// channels using 4-phase req/ack and round-robin grants.
// Optional build macro RX_ARB_LOCAL_PRIO_EN gives Local (port 4) strict
// priority; ports 0-3 then round-robin among themselves.
`ifndef SIZE
`define SIZE 32
`endif

module rx_push_arbiter
  import rx_push_arbiter_pkg::*;
#(
  parameter int          id     = -1,
  parameter int unsigned DATA_W = `SIZE
) (
  input logic               clk,
  input logic               reset,
  rx_push_arbiter_if.master bus
);

  state_e            state_q, state_d;
  port_idx_t         g_q, g_d;
  port_idx_t         ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        ack_q, ack_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] item_q, item_d;
  port_idx_t         grant_q, grant_d;

  logic [4:0]        requesters;
  logic [4:0]        rr_req;
  logic              rr_valid;
  port_idx_t         rr_idx;
  logic              pick_valid;
  port_idx_t         pick_idx;
  logic [DATA_W-1:0] pick_data;
  logic [4:0]        g_onehot;

  // Ports already holding ack are mid-handshake and must not be re-served.
  assign requesters = bus.fifo_push_req & ~ack_q;

`ifdef RX_ARB_LOCAL_PRIO_EN
  assign rr_req     = {1'b0, requesters[3:0]};
  assign pick_valid = requesters[PORT_L] | rr_valid;
  assign pick_idx   = requesters[PORT_L] ? PORT_L : rr_idx;
`else
  assign rr_req     = requesters;
  assign pick_valid = rr_valid;
  assign pick_idx   = rr_idx;
`endif

  rr_pick5 u_pick (
    .req   (rr_req),
    .ptr   (ptr_q),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign pick_data = bus.fifo_push_data[32'(pick_idx) * DATA_W +: DATA_W];
  assign g_onehot  = 5'b00001 << g_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; fifo_full only gates the IDLE decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (pick_valid && !bus.fifo_full) state_d = StWrite;
      StWrite:   state_d = StWaitRel;
      StWaitRel: if (!bus.fifo_push_req[g_q]) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Next values of the grant context and the registered outputs.
  always_comb begin
    g_d     = g_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    ack_d   = '0;
    write_d = 1'b0;
    item_d  = item_q;
    grant_d = GRANT_NONE;
    case (state_q)
      StIdle: begin
        if (pick_valid && !bus.fifo_full) begin
          g_d    = pick_idx;
          data_d = pick_data;
        end
      end
      StWrite: begin
        write_d = 1'b1;
        item_d  = data_q;
        ack_d   = g_onehot;
        grant_d = g_q;
      end
      StWaitRel: begin
        if (bus.fifo_push_req[g_q]) begin
          ack_d   = g_onehot;
          grant_d = g_q;
        end else begin
`ifdef RX_ARB_LOCAL_PRIO_EN
          if (g_q != PORT_L) ptr_d = next_ptr(g_q);
`else
          ptr_d = next_ptr(g_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // Grant context and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q     <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      write_q <= 1'b0;
      item_q  <= '0;
      grant_q <= GRANT_NONE;
    end else begin
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      write_q <= write_d;
      item_q  <= item_d;
      grant_q <= grant_d;
    end
  end

  // Simulation sanity: outside IDLE the latched grant names a real port.
  always_ff @(posedge clk) begin
    if (reset && state_q != StIdle) begin
      assert (g_q < port_idx_t'(NPORTS))
        else $error("rx_push_arbiter %0d: bad grant %0d", id, g_q);
    end
  end

  assign bus.fifo_push_ack = ack_q;
  assign bus.fifo_write    = write_q;
  assign bus.fifo_item_in  = item_q;
  assign bus.grant_port    = grant_q;

endmodule

// File: tb/tb_rx_push_arbiter.sv
// Directed self-checking bench for rx_push_arbiter and its rr_pick5 picker.
module tb_rx_push_arbiter;
  import rx_push_arbiter_pkg::*;

  localparam int unsigned DW = 8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rx_push_arbiter_if #(.DATA_W(DW)) bus ();

  rx_push_arbiter #(.id(3), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [4:0] pk_req;
  port_idx_t  pk_ptr;
  logic       pk_valid;
  port_idx_t  pk_idx;

  rr_pick5 u_pick_ut (
    .req   (pk_req),
    .ptr   (pk_ptr),
    .valid (pk_valid),
    .idx   (pk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic set_data(input int p, input logic [DW-1:0] v);
    bus.fifo_push_data[p*DW +: DW] = v;
  endtask

  task automatic do_reset();
    bus.fifo_push_req = '0;
    bus.fifo_full     = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Zero-delay senders on every port in mask; checks six consecutive writes.
  task automatic run_stream(input string tag, input logic [4:0] mask, input logic [17:0] seq);
    int n;
    logic [2:0] e;
    n = 0;
    bus.fifo_push_req = mask;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      tick();
      if (bus.fifo_write === 1'b1) begin
        e = seq[3*n +: 3];
        check({tag, " item"},  32'(bus.fifo_item_in),  32'(e));
        check({tag, " ack"},   32'(bus.fifo_push_ack), 32'(5'b00001 << e));
        check({tag, " grant"}, 32'(bus.grant_port),    32'(e));
        n++;
      end
      bus.fifo_push_req = mask & ~bus.fifo_push_ack;
    end
    check({tag, " count"}, 32'(n), 32'd6);
    bus.fifo_push_req = '0;
  endtask

  initial begin
    int bad;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.fifo_push_req  = '0;
    bus.fifo_push_data = '0;
    bus.fifo_full      = 1'b0;

    // Standalone picker vectors.
    pk_req = 5'b00000; pk_ptr = 3'd0; #1;
    check("pick none valid", 32'(pk_valid), 32'd0);
    pk_req = 5'b10001; pk_ptr = 3'd1; #1;
    check("pick wrap-to-4", 32'(pk_idx), 32'd4);
    pk_req = 5'b10001; pk_ptr = 3'd0; #1;
    check("pick at ptr", 32'(pk_idx), 32'd0);
    pk_req = 5'b00110; pk_ptr = 3'd4; #1;
    check("pick wrap 4->1", 32'(pk_idx), 32'd1);
    check("pick wrap valid", 32'(pk_valid), 32'd1);
    pk_req = 5'b11111; pk_ptr = 3'd3; #1;
    check("pick all ptr3", 32'(pk_idx), 32'd3);

    // Reset state.
    tick();
    check("rst ack",   32'(bus.fifo_push_ack), 32'd0);
    check("rst write", 32'(bus.fifo_write),    32'd0);
    check("rst item",  32'(bus.fifo_item_in),  32'd0);
    check("rst grant", 32'(bus.grant_port),    32'd7);
    reset = 1'b1;
    tick();

    // Single request on East.
    set_data(2, 8'h5A);
    bus.fifo_push_req = 5'b00100;
    tick();
    check("single pre write", 32'(bus.fifo_write), 32'd0);
    tick();
    check("single write", 32'(bus.fifo_write),    32'd1);
    check("single item",  32'(bus.fifo_item_in),  32'h5A);
    check("single ack",   32'(bus.fifo_push_ack), 32'b00100);
    check("single grant", 32'(bus.grant_port),    32'd2);
    tick();
    check("single write 1cyc", 32'(bus.fifo_write),    32'd0);
    check("single ack held",   32'(bus.fifo_push_ack), 32'b00100);
    bus.fifo_push_req = '0;
    tick();
    check("single ack drop",   32'(bus.fifo_push_ack), 32'd0);
    check("single grant idle", 32'(bus.grant_port),    32'd7);

    // All five ports continuously, data = port index.
    do_reset();
    for (int p = 0; p < 5; p++) set_data(p, DW'(p));
`ifdef RX_ARB_LOCAL_PRIO_EN
    run_stream("all5", 5'b11111, {6{3'd4}});
`else
    run_stream("all5", 5'b11111, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
`endif

    // FIFO full stalls; full rising during WRITE does not cancel it.
    do_reset();
    set_data(1, 8'h3C);
    bus.fifo_full     = 1'b1;
    bus.fifo_push_req = 5'b00010;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fifo_write !== 1'b0 || bus.fifo_push_ack !== 5'b0) bad++;
    end
    check("full stall", 32'(bad), 32'd0);
    bus.fifo_full = 1'b0;
    tick();
    check("full pre write", 32'(bus.fifo_write), 32'd0);
    bus.fifo_full = 1'b1;
    tick();
    check("full write", 32'(bus.fifo_write),    32'd1);
    check("full item",  32'(bus.fifo_item_in),  32'h3C);
    check("full ack",   32'(bus.fifo_push_ack), 32'b00010);
    bus.fifo_push_req = '0;
    tick();
    check("full ack drop", 32'(bus.fifo_push_ack), 32'd0);
    bus.fifo_full = 1'b0;

    // Reset during WAIT_REL; West still requesting gets served again.
    do_reset();
    set_data(3, 8'h33);
    bus.fifo_push_req = 5'b01000;
    tick();
    tick();
    check("rstmid write", 32'(bus.fifo_write), 32'd1);
    tick();
    check("rstmid ack held", 32'(bus.fifo_push_ack), 32'b01000);
    #1;
    reset = 1'b0;
    #1;
    check("rstmid async ack",   32'(bus.fifo_push_ack), 32'd0);
    check("rstmid async grant", 32'(bus.grant_port),    32'd7);
    check("rstmid async write", 32'(bus.fifo_write),    32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rstmid pre write", 32'(bus.fifo_write), 32'd0);
    tick();
    check("rstmid rewrite", 32'(bus.fifo_write),    32'd1);
    check("rstmid reack",   32'(bus.fifo_push_ack), 32'b01000);
    check("rstmid regrant", 32'(bus.grant_port),    32'd3);
    check("rstmid reitem",  32'(bus.fifo_item_in),  32'h33);
    bus.fifo_push_req = '0;
    tick();

    // Slow release on East while North waits.
    do_reset();
    set_data(0, 8'hA0);
    set_data(2, 8'h5A);
    bus.fifo_push_req = 5'b00100;
    tick();
    bus.fifo_push_req = 5'b00101;
    tick();
    check("slow first grant", 32'(bus.grant_port), 32'd2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fifo_push_ack !== 5'b00100 || bus.fifo_write !== 1'b0) bad++;
    end
    check("slow hold", 32'(bad), 32'd0);
    bus.fifo_push_req = 5'b00001;
    tick();
    check("slow release ack", 32'(bus.fifo_push_ack), 32'd0);
    tick();
    check("slow n not yet", 32'(bus.fifo_push_ack), 32'd0);
    tick();
    check("slow n write", 32'(bus.fifo_write),    32'd1);
    check("slow n ack",   32'(bus.fifo_push_ack), 32'b00001);
    check("slow n item",  32'(bus.fifo_item_in),  32'hA0);
    bus.fifo_push_req = '0;
    tick();

    // Local and South both requesting continuously.
    do_reset();
    set_data(1, 8'd1);
    set_data(4, 8'd4);
`ifdef RX_ARB_LOCAL_PRIO_EN
    run_stream("l+s", 5'b10010, {6{3'd4}});
`else
    run_stream("l+s", 5'b10010, {3'd4, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1});
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_push_arbiter.md
Name: rx_push_arbiter

Overview:
- Shares the router's single FIFO write port among the five RX push channels: North, South, East, West and Local.
- Sits between the five RX transceivers and the shared FIFO inside the router.
- Accepts 4-phase req/ack pushes, grants one channel at a time in round-robin order, and writes exactly one flit per completed handshake.
- Stalls all channels while the FIFO reports full.

Parameters:
- id, -1, router id; used only in simulation messages.
- DATA_W, `SIZE, flit width in bits.

Ports:
- clk  input  1  clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- fifo_push_req  input  5  per-port request; bit 0 N, 1 S, 2 E, 3 W, 4 L.
- fifo_push_ack  output  5  per-port acknowledge.
- fifo_push_data  input  5*DATA_W  port i data at [DATA_W*(i+1)-1 : DATA_W*i].
- fifo_write  output  1  one-cycle FIFO write strobe.
- fifo_full  input  1  FIFO full flag.
- fifo_item_in  output  DATA_W  flit presented to the FIFO.
- grant_port  output  3  index of the port in service; 7 when idle (debug).

Behaviour:
- Reset (reset low, asynchronous) forces:
  - fifo_push_ack = 0, fifo_write = 0, fifo_item_in = 0, grant_port = 7
  - state = IDLE, round-robin pointer ptr = 0
- Reset is released synchronously to clk. All outputs are registered.
- Handshake (4-phase, per port):
  - Sender raises req with data stable.
  - Arbiter raises ack after the flit is written.
  - Sender drops req; arbiter drops ack.
  - Data must stay stable while req is high.
- State IDLE:
  - Requesters = fifo_push_req with ack low.
  - If at least one requester exists and fifo_full = 0: pick the first requester at or after ptr, wrapping 4 -> 0.
  - Latch g = picked port and data = fifo_push_data[g]. Go to WRITE.
  - Otherwise remain in IDLE. fifo_full is checked only in IDLE.
- State WRITE (exactly 1 cycle):
  - fifo_write = 1, fifo_item_in = latched data, fifo_push_ack[g] = 1, grant_port = g.
  - Go to WAIT_REL.
- State WAIT_REL:
  - fifo_write = 0; ack[g] is held high.
  - When fifo_push_req[g] is sampled low: next cycle ack[g] = 0, ptr = (g+1) mod 5, grant_port = 7, go to IDLE.
- Latency and throughput:
  - First ack rises 2 edges after req is sampled high in IDLE.
  - Minimum 3 cycles per flit with zero-delay senders.
  - Back-to-back flits from one port are separated by the full 4-phase cycle.
- Fairness: with all five ports requesting continuously, service order is 0,1,2,3,4,0,... Maximum wait is 4 grants.
- Simultaneous events:
  - A new req during WRITE or WAIT_REL waits for IDLE.
  - fifo_full rising during WRITE does not cancel the write; that write is guaranteed to fit because full was low in IDLE.
- Protocol violations:
  - req[g] dropping during WRITE: the write still completes and ack still rises.
  - Requests from ports whose ack is high are ignored.
- Reset mid-operation:
  - An in-flight ack is dropped and no write is issued.
  - A sender still holding req is served again after reset. The flit may be duplicated; this is accepted.
- fifo_item_in holds its last value outside WRITE. It is meaningful only when fifo_write = 1.

Optional Feature:
- Macro: RX_ARB_LOCAL_PRIO_EN.
- Defined: the Local port (bit 4) has strict priority. If req[4] is pending in IDLE it is granted regardless of ptr. Ports 0-3 round-robin among themselves; ptr is updated only on grants to ports 0-3.
- Undefined: pure 5-way round-robin as described above.

Decomposition:
- Shared package/header (alongside the 2-D constants):
  - port indices PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4; NPORTS=5
  - GRANT_NONE=7
  - state encoding IDLE=0, WRITE=1, WAIT_REL=2
- One sub-module, rr_pick5: combinational rotate-priority picker.
  - Inputs: 5-bit request, 3-bit ptr.
  - Outputs: valid, 3-bit index.
  - Instanced once; also unit-tested standalone.

Test Plan:
- Single request: req[2]=1, data E=0x5A, FIFO empty -> fifo_write pulses 1 cycle with item 0x5A; ack[2] rises the same cycle; ack[2] falls 1 cycle after req[2] drops; grant_port returns to 7.
- All five ports request continuously with data = port index -> write order 0,1,2,3,4,0; each port's ack seen exactly once per round.
- fifo_full=1 with req[1]=1 -> no fifo_write and no ack for 20 cycles. full drops -> write occurs 1 cycle after IDLE samples full=0.
- Reset asserted during WAIT_REL (ack[3] high) -> ack[3]=0 and grant_port=7 immediately (asynchronous). req[3] still high after release -> served again from ptr=0.
- Sender delays req drop 10 cycles while req[0] is pending -> port 0 is not acked until port g's handshake completes; then port 0 is granted next.
- With RX_ARB_LOCAL_PRIO_EN and req[4] and req[1] pending continuously -> Local is always granted first; with the macro off, grants alternate 1,4,1,4.
